// File: rtl/flash_read_arbiter.sv
// Flash read-port arbiter: shares the flash manager's single read port
// between the audio streamer (client 0) and the sprite fetcher (client 1).
// Round-robin grant, startup idle gate, watchdog abort on a stuck manager.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// STARTUP(0) | wait for READY_HOLD consecutive idle cycles from the manager
// IDLE(1)    | arbitrate between req0/req1, latch the winner's address
// ISSUE(2)   | doread held high until the manager reports busy
// HOLD(3)    | one extra doread cycle so the manager enters its wait state
// WAIT(4)    | doread low, wait for busy to drop, then return the word
module flash_read_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter logic [3:0]  READY_HOLD     = 4'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [22:0] addr0,
    output logic [15:0] data0,
    output logic        valid0,
    input  logic        req1,
    input  logic [22:0] addr1,
    output logic [15:0] data1,
    output logic        valid1,
    output logic        mgr_writemode,
    output logic        mgr_doread,
    output logic [22:0] mgr_raddr,
    input  logic        mgr_busy,
    input  logic [15:0] mgr_rdata,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        doread_nxt;
    logic [22:0] raddr_nxt;
    logic [15:0] data0_nxt, data1_nxt;
    logic        valid0_nxt, valid1_nxt;
    logic        err_nxt;
    logic        last_grant, last_grant_nxt;
    logic        grant, grant_nxt;
    logic [3:0]  ready_cnt, ready_cnt_nxt;
    logic [19:0] wdog, wdog_nxt;
    logic        pick;
    logic        complete;
    logic        abort;

    assign mgr_writemode = 1'b0;
    assign state_dbg     = state;

    // State and datapath registers; everything returns to its idle value on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_STARTUP;
            mgr_doread  <= 1'b0;
            mgr_raddr   <= 23'd0;
            data0       <= 16'd0;
            data1       <= 16'd0;
            valid0      <= 1'b0;
            valid1      <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            ready_cnt   <= 4'd0;
            wdog        <= 20'd0;
        end else begin
            state       <= state_nxt;
            mgr_doread  <= doread_nxt;
            mgr_raddr   <= raddr_nxt;
            data0       <= data0_nxt;
            data1       <= data1_nxt;
            valid0      <= valid0_nxt;
            valid1      <= valid1_nxt;
            timeout_err <= err_nxt;
            last_grant  <= last_grant_nxt;
            grant       <= grant_nxt;
            ready_cnt   <= ready_cnt_nxt;
            wdog        <= wdog_nxt;
        end
    end

    // Next-state, handshake sequencing, arbitration and watchdog.
    always_comb begin
        state_nxt      = state;
        doread_nxt     = mgr_doread;
        raddr_nxt      = mgr_raddr;
        data0_nxt      = data0;
        data1_nxt      = data1;
        valid0_nxt     = 1'b0;
        valid1_nxt     = 1'b0;
        err_nxt        = timeout_err;
        last_grant_nxt = last_grant;
        grant_nxt      = grant;
        ready_cnt_nxt  = ready_cnt;
        wdog_nxt       = wdog;
        pick           = 1'b0;
        complete       = 1'b0;
        abort          = 1'b0;

        case (state)
            ST_STARTUP: begin
                doread_nxt = 1'b0;
                if (mgr_busy) begin
                    ready_cnt_nxt = 4'd0;
                end else if (ready_cnt == READY_HOLD - 4'd1) begin
                    ready_cnt_nxt = 4'd0;
                    state_nxt     = ST_IDLE;
                end else begin
                    ready_cnt_nxt = ready_cnt + 4'd1;
                end
            end
            ST_IDLE: begin
                doread_nxt = 1'b0;
                // The cycle carrying a valid pulse never grants; arbitration
                // resumes on the following cycle.
                if (!(valid0 || valid1) && (req0 || req1)) begin
                    pick       = (req0 && req1) ? ~last_grant : req1;
                    grant_nxt  = pick;
                    raddr_nxt  = pick ? addr1 : addr0;
                    doread_nxt = 1'b1;
                    wdog_nxt   = TIMEOUT_CYCLES - 20'd1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mgr_busy) begin
                    state_nxt = ST_HOLD;
                end else if (wdog == 20'd0) begin
                    abort = 1'b1;
                end else begin
                    wdog_nxt = wdog - 20'd1;
                end
            end
            ST_HOLD: begin
                doread_nxt = 1'b0;
                wdog_nxt   = TIMEOUT_CYCLES - 20'd1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mgr_busy) begin
                    complete = 1'b1;
                end else if (wdog == 20'd0) begin
                    abort = 1'b1;
                end else begin
                    wdog_nxt = wdog - 20'd1;
                end
            end
            default: begin
                doread_nxt = 1'b0;
                state_nxt  = ST_STARTUP;
            end
        endcase

        if (complete) begin
            if (grant) begin
                data1_nxt  = mgr_rdata;
                valid1_nxt = 1'b1;
            end else begin
                data0_nxt  = mgr_rdata;
                valid0_nxt = 1'b1;
            end
            last_grant_nxt = grant;
            state_nxt      = ST_IDLE;
        end

        // A stuck manager is re-gated through STARTUP before it is used again.
        if (abort) begin
            if (grant) begin
                data1_nxt  = 16'hFFFF;
                valid1_nxt = 1'b1;
            end else begin
                data0_nxt  = 16'hFFFF;
                valid0_nxt = 1'b1;
            end
            err_nxt       = 1'b1;
            doread_nxt    = 1'b0;
            ready_cnt_nxt = 4'd0;
            state_nxt     = ST_STARTUP;
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: behavioural flash manager, per-client
// expected-data queues and a negedge monitor that pops and compares.
module tb_flash_read_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1;
    logic [22:0] addr0, addr1;
    logic [15:0] data0, data1;
    logic        valid0, valid1;
    logic        mgr_writemode, mgr_doread;
    logic [22:0] mgr_raddr;
    logic        mgr_busy;
    logic [15:0] mgr_rdata;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          obs_order[$];
    int          nv0 = 0;
    int          nv1 = 0;
    int          dbusy_cnt = 0;

    bit force_busy = 1'b1;
    bit stuck      = 1'b0;
    bit mrand      = 1'b0;
    int d1 = 1;
    int d2 = 5;

    flash_read_arbiter #(.TIMEOUT_CYCLES(20'd16), .READY_HOLD(4'd4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .valid0(valid0),
        .req1(req1), .addr1(addr1), .data1(data1), .valid1(valid1),
        .mgr_writemode(mgr_writemode), .mgr_doread(mgr_doread),
        .mgr_raddr(mgr_raddr), .mgr_busy(mgr_busy), .mgr_rdata(mgr_rdata),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flash contents as seen by the arbiter: a fixed function of the address.
    function automatic logic [15:0] mem_word(input logic [22:0] a);
        if (a == 23'h000123) return 16'hBEEF;
        return a[15:0] ^ {a[22:16], 9'h0A5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flash manager model: busy rises d1 cycles after doread is seen, stays
    // high d2 cycles (forever while stuck), then presents the word.
    initial begin
        int          ph;
        int          cnt;
        logic [22:0] maddr;
        ph = 0; cnt = 0; maddr = 23'd0;
        mgr_busy = 1'b0; mgr_rdata = 16'd0;
        forever begin
            @(posedge clock); #1;
            if (force_busy) begin
                mgr_busy = 1'b1;
                ph = 3;
            end else begin
                case (ph)
                    0: if (mgr_doread) begin
                        maddr = mgr_raddr;
                        if (mrand) begin
                            d1 = $urandom_range(1, 3);
                            d2 = $urandom_range(1, 6);
                        end
                        cnt = d1;
                        ph = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            mgr_busy = 1'b1;
                            mgr_rdata = 16'h0BAD;
                            cnt = d2;
                            ph = 2;
                        end
                    end
                    2: begin
                        if (!stuck) cnt--;
                        if (cnt <= 0) begin
                            mgr_busy = 1'b0;
                            mgr_rdata = mem_word(maddr);
                            ph = 3;
                        end
                    end
                    default: begin
                        mgr_busy = 1'b0;
                        if (!mgr_doread) ph = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: pops the granted client's expected word on every valid pulse.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clock);
            if (mgr_doread && mgr_busy) dbusy_cnt++;
            if (valid0 && valid1) chk("both_valid", 32'd1, 32'd0);
            if (valid0) begin
                nv0++;
                obs_order.push_back(0);
                chk("doread_with_valid0", {31'd0, mgr_doread}, 32'd0);
                if (q0.size() == 0) chk("unexpected_valid0", {16'd0, data0}, 32'hFFFFFFFF);
                else begin
                    e = q0.pop_front();
                    chk("data0", {16'd0, data0}, {16'd0, e});
                end
            end
            if (valid1) begin
                nv1++;
                obs_order.push_back(1);
                chk("doread_with_valid1", {31'd0, mgr_doread}, 32'd0);
                if (q1.size() == 0) chk("unexpected_valid1", {16'd0, data1}, 32'hFFFFFFFF);
                else begin
                    e = q1.pop_front();
                    chk("data1", {16'd0, data1}, {16'd0, e});
                end
            end
        end
    end

    task automatic wait_valid(input int c);
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if ((c == 0 && valid0) || (c == 1 && valid1)) return;
        end
        chk($sformatf("valid%0d_timeout", c), 32'd0, 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        for (int t = 0; t < lim; t++) begin
            @(negedge clock);
            if (state_dbg == s) return;
        end
        chk("state_wait_timeout", {29'd0, state_dbg}, {29'd0, s});
    endtask

    // One client issuing n reads; rnd picks random addresses, gaps and
    // whether req stays high straight into the next read.
    task automatic client_run(input int c, input int n, input bit rnd);
        logic [22:0] a;
        bit          cont;
        for (int i = 0; i < n; i++) begin
            a = rnd ? 23'($urandom) : ((c == 0) ? 23'h10 : 23'h20);
            if (c == 0) begin addr0 = a; req0 = 1'b1; q0.push_back(mem_word(a)); end
            else        begin addr1 = a; req1 = 1'b1; q1.push_back(mem_word(a)); end
            wait_valid(c);
            cont = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!cont || i == n - 1) begin
                if (c == 0) req0 = 1'b0; else req1 = 1'b0;
                if (rnd) repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
    endtask

    initial begin
        int  run;
        bit  bad;
        bit  seen;
        int  nb;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 23'd0; addr1 = 23'd0;
        repeat (3) @(negedge clock);
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_doread", {31'd0, mgr_doread}, 32'd0);
        chk("rst_raddr", {9'd0, mgr_raddr}, 32'd0);
        chk("rst_data0", {16'd0, data0}, 32'd0);
        chk("rst_data1", {16'd0, data1}, 32'd0);
        chk("rst_valid", {30'd0, valid1, valid0}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("writemode", {31'd0, mgr_writemode}, 32'd0);
        reset = 1'b0;

        // Startup gate: busy held, then exactly 4 idle cycles before IDLE.
        bad = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (mgr_doread || state_dbg != 3'd0) bad = 1'b1;
        end
        chk("startup_gated", {31'd0, bad}, 32'd0);
        force_busy = 1'b0;
        run = 0; seen = 1'b0; bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (state_dbg == 3'd1) begin seen = 1'b1; break; end
            if (mgr_busy) run = 0; else run++;
            if (mgr_doread) bad = 1'b1;
        end
        chk("startup_reached_idle", {31'd0, seen}, 32'd1);
        chk("startup_idle_run", run, 32'd4);
        chk("startup_no_doread", {31'd0, bad}, 32'd0);

        // Single read of 0x123 with a 5-cycle busy window.
        d1 = 1; d2 = 5; mrand = 1'b0;
        dbusy_cnt = 0; nb = nv1;
        addr0 = 23'h000123; req0 = 1'b1; q0.push_back(16'hBEEF);
        wait_valid(0);
        req0 = 1'b0;
        chk("doread_after_busy", dbusy_cnt, 32'd2);
        repeat (3) @(negedge clock);
        chk("no_valid1", nv1, nb);

        // Lone requester is granted back-to-back.
        obs_order.delete();
        client_run(1, 3, 1'b0);
        chk("lone_count", obs_order.size(), 32'd3);
        for (int i = 0; i < obs_order.size(); i++) chk("lone_grant", obs_order[i], 32'd1);

        // Continuous requests from both alternate starting with client 0.
        obs_order.delete();
        fork
            client_run(0, 2, 1'b0);
            client_run(1, 2, 1'b0);
        join
        chk("rr_count", obs_order.size(), 32'd4);
        for (int i = 0; i < obs_order.size(); i++) chk("rr_order", obs_order[i], i % 2);

        // Randomised traffic and manager timing.
        mrand = 1'b1;
        fork
            client_run(0, 15, 1'b1);
            client_run(1, 15, 1'b1);
        join
        mrand = 1'b0;

        // Manager stuck busy: watchdog abort returns FFFF and re-gates.
        d1 = 1; d2 = 3; stuck = 1'b1;
        addr0 = 23'($urandom); req0 = 1'b1; q0.push_back(16'hFFFF);
        wait_valid(0);
        req0 = 1'b0;
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_to_startup", {29'd0, state_dbg}, 32'd0);
        stuck = 1'b0;
        wait_state(3'd1, 100);
        chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of WAIT: no pulse, doread drops, error clears.
        d1 = 1; d2 = 12;
        nb = nv0;
        addr0 = 23'h004567; req0 = 1'b1;
        wait_state(3'd4, 50);
        @(negedge clock);
        req0 = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_doread", {31'd0, mgr_doread}, 32'd0);
        chk("rst_mid_state", {29'd0, state_dbg}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_err", {31'd0, timeout_err}, 32'd0);
        repeat (30) @(negedge clock);
        chk("rst_mid_no_valid", nv0, nb);
        d2 = 4;
        client_run(0, 1, 1'b0);
        chk("post_rst_err", {31'd0, timeout_err}, 32'd0);

        repeat (5) @(negedge clock);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single read port of the flash manager between two read clients: client 0 is the audio sample streamer and client 1 is the graphics/sprite fetcher.
- Sequences the manager's doread/busy handshake, including the manager's requirement that doread be held until busy has been seen.
- Returns the read word to the granted client with a one-cycle valid pulse.
- Uses round-robin arbitration, a startup gate that waits for the manager to become idle, and a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 20'd1000000: cycles allowed in WAIT before the transaction is aborted.
- READY_HOLD, 4'd4: consecutive cycles mgr_busy must read 0 after reset before the first issue.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  client 0 read request (level); held with addr0 until valid0
- addr0  in  23  client 0 word address
- data0  out  16  client 0 read data; updated only on valid0
- valid0  out  1  one-cycle pulse: data0 is fresh
- req1, addr1, data1, valid1: same as client 0, for client 1
- mgr_writemode  out  1  constant 0 (read mode)
- mgr_doread  out  1  drives the manager's doread
- mgr_raddr  out  23  drives the manager's raddr
- mgr_busy  in  1  the manager's busy
- mgr_rdata  in  16  the manager's frdata
- timeout_err  out  1  sticky; set on any watchdog abort
- state_dbg  out  3  current state encoding, for the hex display

Behaviour:
- Reset values:
  - state=STARTUP; mgr_doread=0; mgr_raddr=0.
  - data0=data1=0; valid0=valid1=0; timeout_err=0.
  - last_grant=1, so client 0 wins the first tie; all counters=0.
- Reset asserted in any state aborts the transaction at the next edge with no valid pulse. mgr_doread drops on that same edge.
- STARTUP(0):
  - Count consecutive cycles with mgr_busy=0; any mgr_busy=1 clears the count.
  - When the count reaches READY_HOLD, go to IDLE.
- IDLE(1):
  - If only one req is high, grant that client.
  - If both are high, grant the client that is not last_grant.
  - On a grant: latch its address into mgr_raddr, record the grant, set mgr_doread=1, go to ISSUE.
  - With no req, mgr_doread=0.
- ISSUE(2):
  - Hold mgr_doread=1 and mgr_raddr stable.
  - On the first cycle mgr_busy is sampled 1, go to HOLD.
- HOLD(3):
  - Keep mgr_doread=1 for exactly this one cycle; this gives the manager the second doread cycle it needs to enter its wait state.
  - Then set mgr_doread=0, clear the watchdog, go to WAIT.
- WAIT(4):
  - When mgr_busy is sampled 0: copy mgr_rdata into data of the granted client, pulse its valid for one cycle, set last_grant=granted, go to IDLE.
  - The watchdog counts every WAIT cycle. If it reaches TIMEOUT_CYCLES-1 with mgr_busy still 1:
    - data of the granted client = 16'hFFFF, its valid pulses;
    - timeout_err <= 1;
    - go to STARTUP so the manager is re-gated before further use.
  - The ISSUE state has its own watchdog with the same limit and the same abort action.
- Latency: minimum 4 cycles from the IDLE grant edge to the valid pulse, with the manager answering 1 cycle after HOLD.
- The valid pulse and the next grant never share a cycle. IDLE re-arbitrates on the cycle after the pulse.
- Client contract:
  - A client may deassert req only after its valid pulse.
  - A req dropped early is ignored once granted; the transaction completes and valid still pulses.
- Fairness:
  - Under continuous requests from both clients, grants alternate 0,1,0,1.
  - A lone requester is granted back-to-back.
- Addresses are passed unmodified (23 bits); no arithmetic on the data.
- mgr_raddr changes only on a grant edge.
- timeout_err clears only on reset.

Test Plan:
- Reset, then hold mgr_busy=1 for 10 cycles before releasing it → no mgr_doread until 4 consecutive idle cycles; state_dbg goes 0→1.
- req0 with addr0=23'h000123; manager model raises busy 1 cycle after doread and holds it 5 cycles with rdata=16'hBEEF → doread is high for exactly 2 cycles after busy is first seen; valid0 pulses once with data0=16'hBEEF; valid1 never asserts.
- req0 and req1 raised in the same cycle and held for 4 transactions → grant order 0,1,0,1; each valid pulse carries the rdata for that client's address (addr0=23'h10, addr1=23'h20).
- Only req1 held continuously → consecutive grants to client 1; no cycle has both doread and valid1 high.
- TIMEOUT_CYCLES=16 with mgr_busy stuck at 1 in WAIT → valid0 pulses with data0=16'hFFFF; timeout_err=1; state returns to STARTUP.
- Reset asserted mid-WAIT → mgr_doread=0 and no valid pulse; after STARTUP the next req0 completes normally and timeout_err=0.
